// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM states
// and the supported datapath width.
package lsu_pkg;

  localparam int LSU_XLEN = 32;
  localparam int LSU_STRB = LSU_XLEN / 8;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  function automatic bit xlen_supported(input int xlen);
    return xlen == LSU_XLEN;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response channel from execute plus the data-RAM port, bundled so the
// LSU and its environment share one connection.
interface lsu_if #(
  parameter int XLEN = 32
) ();

  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [XLEN-1:0] req_pc;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_misalign;

  logic              mem_valid;
  logic              mem_write;
  logic              mem_ifetch;
  logic [XLEN-1:0]   mem_pc;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN/8-1:0] mem_strobe;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, req_pc,
    output rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misalign,
    input  mem_valid, mem_write, mem_ifetch, mem_pc, mem_addr, mem_strobe, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, req_pc,
    input  rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misalign,
    output mem_valid, mem_write, mem_ifetch, mem_pc, mem_addr, mem_strobe, mem_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: alignment check, byte strobes, store-data
// replication and load-data extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e                size,
  input  logic [1:0]           addr_lo,
  input  logic                 is_unsigned,
  input  logic [LSU_XLEN-1:0]  wdata,
  input  logic [LSU_XLEN-1:0]  rdata,
  output logic                 misalign,
  output logic [LSU_STRB-1:0]  strobe,
  output logic [LSU_XLEN-1:0]  wdata_rep,
  output logic [LSU_XLEN-1:0]  rdata_ext
);

  logic [LSU_XLEN-1:0] rep_b;
  logic [LSU_XLEN-1:0] rep_h;
  logic [LSU_XLEN-1:0] shifted;

  for (genvar gi = 0; gi < LSU_STRB; gi++) begin : g_lane
    assign rep_b[gi*8 +: 8] = wdata[7:0];
    assign rep_h[gi*8 +: 8] = wdata[(gi%2)*8 +: 8];
  end

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    misalign  = 1'b0;
    strobe    = '0;
    wdata_rep = wdata;
    rdata_ext = shifted;
    case (size)
      SZ_B: begin
        strobe    = 4'b0001 << addr_lo;
        wdata_rep = rep_b;
        rdata_ext = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        misalign  = addr_lo[0];
        strobe    = 4'b0011 << addr_lo;
        wdata_rep = rep_h;
        rdata_ext = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        misalign = |addr_lo;
        strobe   = 4'b1111;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding request FSM in front of a RAM with
// one-cycle read latency; all RAM and response outputs are registered.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic  clk,
  input logic  rst_b,
  lsu_if.slave bus
);

  if (!xlen_supported(XLEN)) begin : g_xlen_check
    $error("lsu: only XLEN=32 is supported");
  end

  state_e            state_q, state_d;
  logic              write_q, write_d;
  size_e             size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        addr_lo_q, addr_lo_d;

  logic              mem_valid_q, mem_valid_d;
  logic              mem_write_q, mem_write_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_pc_q, mem_pc_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [XLEN/8-1:0] mem_strobe_q, mem_strobe_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_misalign_q, rsp_misalign_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic              req_ready;
  logic              accept;
  size_e             al_size;
  logic [1:0]        al_addr_lo;
  logic              al_uns;
  logic              al_misalign;
  logic [LSU_STRB-1:0] al_strobe;
  logic [LSU_XLEN-1:0] al_wdata;
  logic [LSU_XLEN-1:0] al_rdata;

  assign req_ready = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
  assign accept    = bus.req_valid && req_ready;

  // WAIT extracts load data from the latched request; every other state
  // decodes the request currently being offered.
  assign al_size    = (state_q == WAIT) ? size_q    : size_e'(bus.req_size);
  assign al_addr_lo = (state_q == WAIT) ? addr_lo_q : bus.req_addr[1:0];
  assign al_uns     = (state_q == WAIT) ? uns_q     : bus.req_unsigned;

  lsu_align u_align (
    .size        (al_size),
    .addr_lo     (al_addr_lo),
    .is_unsigned (al_uns),
    .wdata       (bus.req_wdata),
    .rdata       (bus.mem_rdata),
    .misalign    (al_misalign),
    .strobe      (al_strobe),
    .wdata_rep   (al_wdata),
    .rdata_ext   (al_rdata)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q        <= IDLE;
      write_q        <= 1'b0;
      size_q         <= SZ_B;
      uns_q          <= 1'b0;
      addr_lo_q      <= 2'b00;
      mem_valid_q    <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_addr_q     <= '0;
      mem_pc_q       <= '0;
      mem_wdata_q    <= '0;
      mem_strobe_q   <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_misalign_q <= 1'b0;
      rsp_rdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      write_q        <= write_d;
      size_q         <= size_d;
      uns_q          <= uns_d;
      addr_lo_q      <= addr_lo_d;
      mem_valid_q    <= mem_valid_d;
      mem_write_q    <= mem_write_d;
      mem_addr_q     <= mem_addr_d;
      mem_pc_q       <= mem_pc_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_strobe_q   <= mem_strobe_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_misalign_q <= rsp_misalign_d;
      rsp_rdata_q    <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = al_misalign ? RESP : ACCESS;
      ACCESS: state_d = write_q ? RESP : WAIT;
      WAIT:   state_d = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          if (accept) state_d = al_misalign ? RESP : ACCESS;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    write_d        = write_q;
    size_d         = size_q;
    uns_d          = uns_q;
    addr_lo_d      = addr_lo_q;
    mem_valid_d    = 1'b0;
    mem_write_d    = 1'b0;
    mem_strobe_d   = '0;
    mem_wdata_d    = '0;
    mem_addr_d     = mem_addr_q;
    mem_pc_d       = mem_pc_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_misalign_d = rsp_misalign_q;

    // A consumed response clears its payload so stores and faults read back 0.
    if ((state_q == RESP) && bus.rsp_ready) begin
      rsp_rdata_d    = '0;
      rsp_misalign_d = 1'b0;
    end
    if (state_q == WAIT) rsp_rdata_d = al_rdata;

    if (accept) begin
      write_d        = bus.req_write;
      size_d         = al_size;
      uns_d          = bus.req_unsigned;
      addr_lo_d      = bus.req_addr[1:0];
      mem_addr_d     = {bus.req_addr[XLEN-1:2], 2'b00};
      mem_pc_d       = bus.req_pc;
      rsp_misalign_d = al_misalign;
      if (!al_misalign) begin
        mem_valid_d  = 1'b1;
        mem_write_d  = bus.req_write;
        mem_strobe_d = al_strobe;
        mem_wdata_d  = bus.req_write ? al_wdata : '0;
      end
    end

    rsp_valid_d = (state_d == RESP);
  end

  assign bus.req_ready    = req_ready;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_misalign = rsp_misalign_q;
  assign bus.mem_valid    = mem_valid_q;
  assign bus.mem_write    = mem_write_q;
  assign bus.mem_ifetch   = 1'b0;
  assign bus.mem_pc       = mem_pc_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_strobe   = mem_strobe_q;
  assign bus.mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: table of single transactions against a behavioural RAM, plus
// back-pressure/back-to-back and mid-load reset sequences, checked via scoreboards.
module tb_lsu;
  import lsu_pkg::*;

  typedef struct {
    string       name;
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pre;
    logic [31:0] pre_word;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    logic [3:0]  exp_strb;
    logic [31:0] exp_mwdata;
    int          exp_lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        mis;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [3:0]  strb;
    logic        w;
  } mem_t;

  logic clk;
  logic rst_b;
  int   total = 0;
  int   bad   = 0;

  rsp_t rsp_q[$];
  mem_t mem_q[$];
  vec_t vecs[$];
  logic [31:0] ram [logic [31:0]];

  lsu_if #(.XLEN(32)) bus ();

  lsu #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Behavioural RAM: one-cycle read latency, strobed writes, ignores the bus in reset.
  always @(posedge clk) begin : ram_model
    logic [31:0] word;
    if (rst_b && bus.mem_valid) begin
      word = ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : 32'h0;
      if (bus.mem_write) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_strobe[b]) word[b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
        ram[bus.mem_addr] = word;
      end else begin
        bus.mem_rdata <= word;
      end
    end
  end

  always @(negedge clk) begin : monitor
    mem_t m;
    rsp_t r;
    if (rst_b) begin
      if (bus.mem_valid) begin
        if (mem_q.size() == 0) check("mem_valid_unexpected", bus.mem_valid, 0);
        else begin
          m = mem_q.pop_front();
          check("mem_addr", bus.mem_addr, m.addr);
          check("mem_strobe", bus.mem_strobe, m.strb);
          check("mem_write", bus.mem_write, m.w);
          check("mem_pc", bus.mem_pc, m.pc);
          if (m.w) check("mem_wdata", bus.mem_wdata, m.wdata);
        end
      end else begin
        check("mem_idle", {bus.mem_write, bus.mem_strobe, bus.mem_wdata}, 0);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", bus.rsp_valid, 0);
        else begin
          r = rsp_q.pop_front();
          $display("txn %s: rdata=%h misalign=%b", r.name, bus.rsp_rdata, bus.rsp_misalign);
          check({r.name, "_rdata"}, bus.rsp_rdata, r.rdata);
          check({r.name, "_misalign"}, bus.rsp_misalign, r.mis);
        end
      end
    end
  end

  function automatic vec_t mk(input string n, input logic w, input logic [1:0] sz, input logic u,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic pre,
                              input logic [31:0] pre_word, input logic [31:0] exp_rdata,
                              input logic exp_mis, input logic [3:0] exp_strb,
                              input logic [31:0] exp_mwdata, input int exp_lat);
    vec_t v;
    v.name = n; v.w = w; v.sz = sz; v.u = u; v.addr = addr; v.wdata = wdata;
    v.pre = pre; v.pre_word = pre_word; v.exp_rdata = exp_rdata; v.exp_mis = exp_mis;
    v.exp_strb = exp_strb; v.exp_mwdata = exp_mwdata; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic drive_req(input vec_t v, input logic [31:0] pc);
    rsp_t r;
    mem_t m;
    if (v.pre) ram[{v.addr[31:2], 2'b00}] = v.pre_word;
    bus.req_write    = v.w;
    bus.req_size     = v.sz;
    bus.req_unsigned = v.u;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    bus.req_pc       = pc;
    bus.req_valid    = 1'b1;
    r.name = v.name; r.rdata = v.exp_rdata; r.mis = v.exp_mis;
    rsp_q.push_back(r);
    if (!v.exp_mis) begin
      m.addr = {v.addr[31:2], 2'b00}; m.wdata = v.exp_mwdata; m.pc = pc;
      m.strb = v.exp_strb; m.w = v.w;
      mem_q.push_back(m);
    end
  endtask

  task automatic wait_accept(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready && n < 20);
    check({name, "_req_ready"}, bus.req_ready, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int exp_lat);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 10);
    check({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic run_vec(input vec_t v, input logic [31:0] pc);
    int n;
    drive_req(v, pc);
    wait_accept(v.name, n);
    wait_rsp(v.name, v.exp_lat);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    check({tag, "_rsp_misalign"}, bus.rsp_misalign, 0);
    check({tag, "_mem_valid"}, bus.mem_valid, 0);
    check({tag, "_mem_ctl"}, {bus.mem_write, bus.mem_ifetch, bus.mem_strobe}, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_mem_pc"}, bus.mem_pc, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   n;
    vec_t v;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_pc = '0; bus.rsp_ready = 1'b1;
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk);
    #1;
    rst_b = 1'b1;

    //               name        w sz u addr          wdata         pre pre_word      rdata         mis strb  mwdata        lat
    vecs.push_back(mk("lw",       0, 2, 0, 32'h1000, 32'h0,        1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 4'hF, 32'h0,        3));
    vecs.push_back(mk("lb_neg",   0, 0, 0, 32'h1003, 32'h0,        1, 32'h80FF7F01, 32'hFFFFFF80, 0, 4'h8, 32'h0,        3));
    vecs.push_back(mk("lbu",      0, 0, 1, 32'h1003, 32'h0,        0, 32'h0,        32'h00000080, 0, 4'h8, 32'h0,        3));
    vecs.push_back(mk("lh_neg",   0, 1, 0, 32'h1002, 32'h0,        0, 32'h0,        32'hFFFF80FF, 0, 4'hC, 32'h0,        3));
    vecs.push_back(mk("lhu_lo",   0, 1, 1, 32'h1000, 32'h0,        0, 32'h0,        32'h00007F01, 0, 4'h3, 32'h0,        3));
    vecs.push_back(mk("lb_pos",   0, 0, 0, 32'h1001, 32'h0,        0, 32'h0,        32'h0000007F, 0, 4'h2, 32'h0,        3));
    vecs.push_back(mk("lh_pos",   0, 1, 0, 32'h1000, 32'h0,        0, 32'h0,        32'h00007F01, 0, 4'h3, 32'h0,        3));
    vecs.push_back(mk("lbu_b2",   0, 0, 1, 32'h1002, 32'h0,        0, 32'h0,        32'h000000FF, 0, 4'h4, 32'h0,        3));
    vecs.push_back(mk("sb",       1, 0, 0, 32'h2001, 32'h123456AB, 1, 32'h11223344, 32'h0,        0, 4'h2, 32'hABABABAB, 2));
    vecs.push_back(mk("lw_sb",    0, 2, 0, 32'h2000, 32'h0,        0, 32'h0,        32'h1122AB44, 0, 4'hF, 32'h0,        3));
    vecs.push_back(mk("sh",       1, 1, 0, 32'h2002, 32'hFFFFBEEF, 0, 32'h0,        32'h0,        0, 4'hC, 32'hBEEFBEEF, 2));
    vecs.push_back(mk("lw_sh",    0, 2, 0, 32'h2000, 32'h0,        0, 32'h0,        32'hBEEFAB44, 0, 4'hF, 32'h0,        3));
    vecs.push_back(mk("sw",       1, 2, 0, 32'h3000, 32'hCAFEF00D, 0, 32'h0,        32'h0,        0, 4'hF, 32'hCAFEF00D, 2));
    vecs.push_back(mk("lbu_fe",   0, 0, 1, 32'h3002, 32'h0,        0, 32'h0,        32'h000000FE, 0, 4'h4, 32'h0,        3));
    vecs.push_back(mk("lb_fe",    0, 0, 0, 32'h3002, 32'h0,        0, 32'h0,        32'hFFFFFFFE, 0, 4'h4, 32'h0,        3));
    vecs.push_back(mk("lh_hi",    0, 1, 0, 32'h3002, 32'h0,        0, 32'h0,        32'hFFFFCAFE, 0, 4'hC, 32'h0,        3));
    vecs.push_back(mk("lw_mis",   0, 2, 0, 32'h1002, 32'h0,        0, 32'h0,        32'h0,        1, 4'h0, 32'h0,        1));
    vecs.push_back(mk("sh_mis",   1, 1, 0, 32'h1001, 32'h5555AAAA, 0, 32'h0,        32'h0,        1, 4'h0, 32'h0,        1));
    vecs.push_back(mk("sz3",      0, 3, 0, 32'h1000, 32'h0,        0, 32'h0,        32'h0,        1, 4'h0, 32'h0,        1));
    vecs.push_back(mk("lhu_mis",  0, 1, 1, 32'h1003, 32'h0,        0, 32'h0,        32'h0,        1, 4'h0, 32'h0,        1));
    vecs.push_back(mk("sw_mis",   1, 2, 0, 32'h3001, 32'h11111111, 0, 32'h0,        32'h0,        1, 4'h0, 32'h0,        1));
    vecs.push_back(mk("lw_intact",0, 2, 0, 32'h3000, 32'h0,        0, 32'h0,        32'hCAFEF00D, 0, 4'hF, 32'h0,        3));
    vecs.push_back(mk("sb_b3",    1, 0, 0, 32'h3003, 32'hFFFFFF5A, 0, 32'h0,        32'h0,        0, 4'h8, 32'h5A5A5A5A, 2));
    vecs.push_back(mk("lw_sb3",   0, 2, 0, 32'h3000, 32'h0,        0, 32'h0,        32'h5AFEF00D, 0, 4'hF, 32'h0,        3));

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], 32'h400 + 32'(4 * i));

    // Back-pressure for five cycles, then release together with a new store.
    v = mk("bp_lw", 0, 2, 0, 32'h1000, 32'h0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 4'hF, 32'h0, 3);
    drive_req(v, 32'h800);
    wait_accept("bp_lw", n);
    bus.rsp_ready = 1'b0;
    wait_rsp("bp_lw", 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", bus.rsp_valid, 1);
      check("bp_hold_rdata", bus.rsp_rdata, 32'hDEADBEEF);
      check("bp_req_ready_low", bus.req_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    v = mk("b2b_sb", 1, 0, 0, 32'h2001, 32'h000000AB, 0, 32'h0, 32'h0, 0, 4'h2, 32'hABABABAB, 2);
    drive_req(v, 32'h804);
    wait_accept("b2b_sb", n);
    check("b2b_same_edge", n, 1);
    @(negedge clk);
    check("b2b_access", bus.mem_valid, 1);
    @(negedge clk);
    check("b2b_rsp", bus.rsp_valid, 1);
    @(posedge clk);
    #1;

    // Reset asserted while the load waits for RAM data.
    v = mk("rst_lw", 0, 2, 0, 32'h1000, 32'h0, 1, 32'h01234567, 32'h01234567, 0, 4'hF, 32'h0, 3);
    drive_req(v, 32'h900);
    wait_accept("rst_lw", n);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    check_reset("mid_reset");
    rsp_q.delete();
    mem_q.delete();
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    @(negedge clk);
    check("post_reset_req_ready", bus.req_ready, 1);
    check("post_reset_rsp_valid", bus.rsp_valid, 0);
    @(posedge clk);
    #1;
    run_vec(mk("post_rst_lh", 0, 1, 0, 32'h1002, 32'h0, 1, 32'h80FF7F01, 32'hFFFF80FF, 0, 4'hC, 32'h0, 3), 32'h904);

    check("scoreboard_drained", rsp_q.size() + mem_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
